axilite_code_loader: RTL
========================

// Module: axilite_code_loader
// PURPOSE
// - AXI-Lite master that loads a BPF program into the packet filter's register slave (Control, inst_low, inst_high, Status).
// - Fetches 64-bit instructions from a local code ROM, stops the filter, writes each instruction, then restarts the filter.
// - Sits beside axistream_packetfilt, e.g. for boot-time program load without a CPU.
// PARAMETERS
// - INST_MEM_DEPTH  512    filter code memory depth; CODE_ADDR_WIDTH = CLOG2(INST_MEM_DEPTH)
// - AXI_ADDR_WIDTH  12     must match the slave
// - BASE_ADDR       0      filter register base; offsets STATUS 0x0, CONTROL 0x4, INST_LOW 0x8, INST_HIGH 0xC
// - POLL_CYCLES     1024   Status poll period in clk cycles (STATUS_POLL_EN only)
// PORTS
// - clk                 in   1                 clock
// - rst                 in   1                 synchronous, active-high reset
// - start               in   1                 pulse: begin load; ignored while busy=1
// - prog_len            in   CODE_ADDR_WIDTH+1 instruction count, sampled on accepted start
// - rom_addr            out  CODE_ADDR_WIDTH   code ROM read address
// - rom_rd_en           out  1                 ROM read strobe
// - rom_data            in   64                ROM data, valid exactly 1 cycle after rom_rd_en
// - m_axi_aw{addr,prot,valid}/awready, w{data,strb,valid}/wready, b{resp,valid}/bready   write channels
// - m_axi_ar{addr,prot,valid}/arready, r{data,resp,valid}/rready                          read channels
// - busy                out  1                 1 from accepted start until DONE/abort
// - done                out  1                 1-cycle pulse after Control=1 write completes with OKAY
// - err                 out  1                 sticky: a non-OKAY bresp/rresp was seen; cleared on next accepted start
// - num_packets_dropped out  16                last polled Status[15:0] (STATUS_POLL_EN only)
// BEHAVIOUR
// - Reset: all *valid=0, bready=0, rready=0, rom_rd_en=0, rom_addr=0, busy=0, done=0, err=0, num_packets_dropped=0; FSM -> IDLE.
// - Constant outputs: awprot=arprot=3'b000, wstrb=4'hF.
// - FSM: IDLE -> STOP (write CONTROL=0) -> FETCH (rom_rd_en, addr=i) -> ROM_WAIT (latch rom_data)
//   -> WR_LOW (INST_LOW=data[31:0]) -> WR_HIGH (INST_HIGH=data[63:32]; slave commits on this write)
//   -> i+1<len ? FETCH : RUN (write CONTROL=1) -> IDLE with done pulse.
// - len = min(prog_len, INST_MEM_DEPTH); len=0 goes STOP -> RUN directly. i counts 0..len-1 and never wraps.
// - Write handshake: awvalid and wvalid rise in the same cycle; each drops independently in the cycle after its ready
//   is seen; bready=1 from awvalid rise until bvalid; next write starts the cycle after the B handshake.
//   addr/data stable while valid. One outstanding transaction max; ready may arrive in any order, incl. same cycle.
// - Minimum latency per write: 3 cycles (issue, AW/W accept, B). Per instruction: 2 ROM cycles + 2 writes.
// - bresp!=2'b00: err=1, abort to IDLE, busy=0, no done, CONTROL=1 never written (filter stays stopped).
// - start and an abort in the same cycle: abort wins; start is ignored.
// - rst mid-transaction: valids drop immediately (slave shares the reset, so this is legal here).
// CONFIGURATION
// - STATUS_POLL_EN defined: in IDLE after the first successful load, a read of STATUS is issued every POLL_CYCLES;
//   arvalid held until arready; rready=1 until rvalid; num_packets_dropped<=rdata[15:0] on OKAY.
//   rresp!=OKAY sets err. An accepted start waits for any in-flight read to finish, then takes priority over polling.
// - STATUS_POLL_EN undefined: AR/R outputs tied 0 (arvalid=0, rready=0); num_packets_dropped=0; no poll counter.
// STRUCTURE
// - Package axilite_code_loader_pkg: register offsets, OKAY code, FSM state encoding, CLOG2 macro.
// - Sub-module axilite_wr_engine: one AW/W/B write with req/ack/resp, reused for every write; the FSM stays in the top.
// TESTING
// - prog_len=3, ROM={64'h1111_2222_3333_4444,..}, always-ready slave -> writes 0x4=0, 0x8=0x33334444, 0xC=0x11112222, .., 0x4=1; done once.
// - prog_len=0 -> exactly two writes (0x4=0, 0x4=1), then done.
// - wready 5 cycles before awready, then same-cycle readies -> no duplicate or lost writes; data matches ROM.
// - bresp=2'b10 on 2nd INST_HIGH -> err=1, busy=0, no CONTROL=1 write; next start clears err.
// - prog_len=600 with INST_MEM_DEPTH=512 -> 512 instruction pairs written; start pulsed mid-load is ignored.
// - STATUS_POLL_EN, POLL_CYCLES=16, rdata=0x0000_002A -> num_packets_dropped=42 within 20 cycles; rst mid-AW -> all valids 0 next cycle.

Source files
------------

// File: rtl/axilite_code_loader_pkg.sv
// Shared constants for the code loader: filter register map, AXI response code, FSM encoding.
`ifndef AXILITE_CODE_LOADER_PKG_MACROS
`define AXILITE_CODE_LOADER_PKG_MACROS
`define CLOG2(x) $clog2(x)
`endif

package axilite_code_loader_pkg;
    localparam logic [3:0] OFF_STATUS    = 4'h0;
    localparam logic [3:0] OFF_CONTROL   = 4'h4;
    localparam logic [3:0] OFF_INST_LOW  = 4'h8;
    localparam logic [3:0] OFF_INST_HIGH = 4'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_STOP     = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_ROM_WAIT = 3'd3;
    localparam logic [2:0] S_WR_LOW   = 3'd4;
    localparam logic [2:0] S_WR_HIGH  = 3'd5;
    localparam logic [2:0] S_RUN      = 3'd6;
endpackage

// File: rtl/axilite_wr_engine.sv
// Single AXI-Lite write: AW and W raised together, each dropped after its own ready,
// bready held until the response; ack pulses combinationally on the B handshake.
module axilite_wr_engine #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    output logic              ack,
    output logic [1:0]        resp,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    logic launch;

    // bready doubles as the "transaction outstanding" flag.
    assign launch = req && !bready;
    assign ack    = bready && bvalid;
    assign resp   = bresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
        end else if (launch) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            bready  <= 1'b1;
            awaddr  <= addr;
            wdata   <= data;
        end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (bready && bvalid)   bready  <= 1'b0;
        end
    end
endmodule

// File: rtl/axilite_code_loader.sv
// Boot-time BPF loader: stops the filter, writes each ROM instruction as LOW/HIGH halves, restarts it.
// Define STATUS_POLL_EN to poll the Status register (drop counter) while idle after a good load.
module axilite_code_loader
    import axilite_code_loader_pkg::*;
#(
    parameter int                        INST_MEM_DEPTH  = 512,
    parameter int                        AXI_ADDR_WIDTH  = 12,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                        POLL_CYCLES     = 1024,
    localparam int                       CODE_ADDR_WIDTH = `CLOG2(INST_MEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CODE_ADDR_WIDTH:0]   prog_len,
    output logic [CODE_ADDR_WIDTH-1:0] rom_addr,
    output logic                       rom_rd_en,
    input  logic [63:0]                rom_data,
    output logic [AXI_ADDR_WIDTH-1:0]  m_axi_awaddr,
    output logic [2:0]                 m_axi_awprot,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [31:0]                m_axi_wdata,
    output logic [3:0]                 m_axi_wstrb,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [31:0]                m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [15:0]                num_packets_dropped
);
    localparam int               LEN_W   = CODE_ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(INST_MEM_DEPTH);

    logic [2:0]                state;
    logic [LEN_W-1:0]          len, idx, idx_next;
    logic [63:0]               inst;
    logic                      wr_req, wr_ack;
    logic [1:0]                wr_resp;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]               wr_data;
    logic                      rd_busy, rd_err;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;
    assign m_axi_araddr = BASE_ADDR + AXI_ADDR_WIDTH'(OFF_STATUS);
    assign busy         = (state != S_IDLE);
    assign rom_rd_en    = (state == S_FETCH);
    assign rom_addr     = idx[CODE_ADDR_WIDTH-1:0];
    assign idx_next     = idx + 1'b1;

    always_comb begin
        wr_req  = 1'b0;
        wr_addr = BASE_ADDR + AXI_ADDR_WIDTH'(OFF_CONTROL);
        wr_data = 32'd0;
        case (state)
            S_STOP:    wr_req = !rd_busy;   // let an in-flight Status read drain first
            S_WR_LOW:  begin
                wr_req  = 1'b1;
                wr_addr = BASE_ADDR + AXI_ADDR_WIDTH'(OFF_INST_LOW);
                wr_data = inst[31:0];
            end
            S_WR_HIGH: begin
                wr_req  = 1'b1;
                wr_addr = BASE_ADDR + AXI_ADDR_WIDTH'(OFF_INST_HIGH);
                wr_data = inst[63:32];
            end
            S_RUN:     begin
                wr_req  = 1'b1;
                wr_data = 32'd1;
            end
            default:   ;
        endcase
    end

    axilite_wr_engine #(.ADDR_W(AXI_ADDR_WIDTH)) u_wr (
        .clk(clk), .rst(rst), .req(wr_req), .addr(wr_addr), .data(wr_data),
        .ack(wr_ack), .resp(wr_resp),
        .awaddr(m_axi_awaddr), .awvalid(m_axi_awvalid), .awready(m_axi_awready),
        .wdata(m_axi_wdata), .wvalid(m_axi_wvalid), .wready(m_axi_wready),
        .bresp(m_axi_bresp), .bvalid(m_axi_bvalid), .bready(m_axi_bready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            len   <= '0;
            idx   <= '0;
            inst  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            // A failed write leaves the filter stopped: CONTROL=1 is never issued.
            if (wr_ack && wr_resp != RESP_OKAY) begin
                err   <= 1'b1;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        len   <= (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                        idx   <= '0;
                        err   <= 1'b0;
                        state <= S_STOP;
                    end
                    S_STOP:     if (wr_ack) state <= (len == '0) ? S_RUN : S_FETCH;
                    S_FETCH:    state <= S_ROM_WAIT;
                    S_ROM_WAIT: begin
                        inst  <= rom_data;
                        state <= S_WR_LOW;
                    end
                    S_WR_LOW:   if (wr_ack) state <= S_WR_HIGH;
                    S_WR_HIGH:  if (wr_ack) begin
                        if (idx_next < len) begin
                            idx   <= idx_next;
                            state <= S_FETCH;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                    S_RUN:      if (wr_ack) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default:    state <= S_IDLE;
                endcase
            end
            if (rd_err) err <= 1'b1;
        end
    end

`ifdef STATUS_POLL_EN
    localparam int PCNT_W = $clog2(POLL_CYCLES) + 1;

    logic [PCNT_W-1:0] poll_cnt;
    logic              loaded, ar_valid, r_ready;
    logic [15:0]       dropped;
    logic              unused_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
            loaded   <= 1'b0;
            ar_valid <= 1'b0;
            r_ready  <= 1'b0;
            dropped  <= '0;
        end else begin
            if (done) loaded <= 1'b1;
            if (ar_valid && m_axi_arready) ar_valid <= 1'b0;
            if (r_ready && m_axi_rvalid) begin
                r_ready <= 1'b0;
                if (m_axi_rresp == RESP_OKAY) dropped <= m_axi_rdata[15:0];
            end
            // A start in this cycle moves the FSM out of IDLE, so it beats a due poll.
            if (state == S_IDLE && loaded && !r_ready && !start) begin
                if (poll_cnt == PCNT_W'(POLL_CYCLES - 1)) begin
                    poll_cnt <= '0;
                    ar_valid <= 1'b1;
                    r_ready  <= 1'b1;
                end else begin
                    poll_cnt <= poll_cnt + 1'b1;
                end
            end else if (state != S_IDLE) begin
                poll_cnt <= '0;
            end
        end
    end

    assign rd_busy             = r_ready;
    assign rd_err              = r_ready && m_axi_rvalid && (m_axi_rresp != RESP_OKAY);
    assign m_axi_arvalid       = ar_valid;
    assign m_axi_rready        = r_ready;
    assign num_packets_dropped = dropped;
    assign unused_rd           = ^m_axi_rdata[31:16];
`else
    logic unused_rd;

    assign rd_busy             = 1'b0;
    assign rd_err              = 1'b0;
    assign m_axi_arvalid       = 1'b0;
    assign m_axi_rready        = 1'b0;
    assign num_packets_dropped = 16'd0;
    assign unused_rd           = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, (POLL_CYCLES != 0)};
`endif
endmodule
